// File: rtl/branch_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branchCtrlPkg
// Description : Shared types, constants and helpers for the branch redirect
//               controller: FSM state encoding, source count, the
//               "sequential" select code and source/select mapping helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package branchCtrlPkg;

    localparam int         DEFAULT_ADDR_SIZE = 20;
    localparam int         NUM_SRC           = 3;
    localparam logic [1:0] SEL_SEQ           = 2'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } ctrlState_t;

    // Source i is presented to the branch unit as select code i+1.
    function automatic logic [1:0] srcToSel(input logic [1:0] src);
        return src + 2'd1;
    endfunction

    // Index of the set bit in a one-hot source vector (0 when empty).
    function automatic logic [1:0] oneHotToSrc(input logic [NUM_SRC-1:0] oneHot);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (oneHot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Source following src in round-robin order.
    function automatic logic [1:0] nextSrc(input logic [1:0] src);
        return (src == 2'(NUM_SRC - 1)) ? 2'd0 : src + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl_if
// Description : Redirect request handshake between the three redirect sources
//               and the controller.
//               reqValid[2:0]   - per-source request (source side drives)
//               reqTarget0..2   - per-source redirect address
//               reqReady[2:0]   - one-hot grant (controller drives)
//               master modport : request sources
//               slave  modport : controller
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_redirect_ctrl_if
    import branchCtrlPkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
);
    logic [NUM_SRC-1:0]   reqValid;
    logic [ADDR_SIZE-1:0] reqTarget0;
    logic [ADDR_SIZE-1:0] reqTarget1;
    logic [ADDR_SIZE-1:0] reqTarget2;
    logic [NUM_SRC-1:0]   reqReady;

    modport master (
        output reqValid, reqTarget0, reqTarget1, reqTarget2,
        input  reqReady
    );

    modport slave (
        input  reqValid, reqTarget0, reqTarget1, reqTarget2,
        output reqReady
    );
endinterface
`default_nettype wire

// File: rtl/branch_redirect_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : redirectArbiter
// Description : Combinational one-hot arbiter over the redirect sources.
//               The search begins at 'pointer' and wraps; with pointer tied
//               to 0 this is plain fixed priority (source 0 highest).
//               reqValid[2:0] - requesting sources
//               enable        - grants are only issued when high
//               pointer[1:0]  - first source examined (out-of-range -> 0)
//               grant[2:0]    - one-hot winner, zero when disabled/idle
// Revision    : 1.0 - initial release
// ============================================================================
module redirectArbiter
    import branchCtrlPkg::*;
(
    input  logic [NUM_SRC-1:0] reqValid,
    input  logic               enable,
    input  logic [1:0]         pointer,
    output logic [NUM_SRC-1:0] grant
);

    logic [1:0] w_start;
    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = 2'd0;
        w_start = (pointer >= 2'(NUM_SRC)) ? 2'd0 : pointer;
        for (int n = 0; n < NUM_SRC; n++) begin
            w_idx = 2'((32'(w_start) + 32'(n)) % NUM_SRC);
            if (enable && !w_found && reqValid[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Arbitrates redirect requests from three sources and steers
//               the branch unit: one REDIRECT cycle presenting the chosen
//               target, then FLUSH_CYCLES bubble cycles, then back to IDLE.
//               Build option BRANCH_RR_ARB_EN selects round-robin
//               arbitration; without it, fixed priority (source 0 first).
//   clk            - rising-edge clock
//   reset          - asynchronous active-low reset
//   req            - request handshake (slave modport)
//   extStall       - external hold
//   selWire[1:0]   - 0 sequential, i+1 selects source i target
//   jumpTarget1..3 - latched targets for sources 0..2
//   pcStall        - freeze request to the branch unit
//   busy           - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl
    import branchCtrlPkg::*;
#(
    parameter int ADDR_SIZE    = DEFAULT_ADDR_SIZE,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_redirect_ctrl_if.slave req,
    input  logic                  extStall,
    output logic [1:0]            selWire,
    output logic [ADDR_SIZE-1:0]  jumpTarget1,
    output logic [ADDR_SIZE-1:0]  jumpTarget2,
    output logic [ADDR_SIZE-1:0]  jumpTarget3,
    output logic                  pcStall,
    output logic                  busy
);

    localparam logic [3:0] c_FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    ctrlState_t           r_state;
    logic [3:0]           r_flushCnt;
    logic [1:0]           r_selWire;
    logic                 r_pcStall;
    logic                 r_busy;

    logic [NUM_SRC-1:0]   w_grant;
    logic [1:0]           w_grantIdx;
    logic [1:0]           w_arbPtr;
    logic                 w_arbEnable;
    logic                 w_transfer;
    logic [ADDR_SIZE-1:0] w_target [NUM_SRC];

    assign w_target[0] = req.reqTarget0;
    assign w_target[1] = req.reqTarget1;
    assign w_target[2] = req.reqTarget2;

    // Grants are withheld while reset is asserted so no handshake can
    // complete that the controller would then ignore.
    assign w_arbEnable = reset && (r_state == IDLE) && !extStall;

    redirectArbiter u_arbiter (
        .reqValid (req.reqValid),
        .enable   (w_arbEnable),
        .pointer  (w_arbPtr),
        .grant    (w_grant)
    );

    assign req.reqReady = w_grant;
    assign w_transfer   = |(req.reqValid & w_grant);
    assign w_grantIdx   = oneHotToSrc(w_grant);

`ifdef BRANCH_RR_ARB_EN
    logic [1:0] r_rrPtr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rrPtr <= 2'd0;
        end else if (w_transfer) begin
            r_rrPtr <= nextSrc(w_grantIdx);
        end
    end

    assign w_arbPtr = r_rrPtr;
`else
    assign w_arbPtr = 2'd0;
`endif

    // Each target register only follows its own source's transfer.
    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_jumpTarget
            logic [ADDR_SIZE-1:0] r_jumpTarget;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_jumpTarget <= '0;
                end else if (w_transfer && w_grant[i]) begin
                    r_jumpTarget <= w_target[i];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_flushCnt <= 4'd0;
            r_selWire  <= SEL_SEQ;
            r_pcStall  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_transfer) begin
                        r_state   <= REDIRECT;
                        r_selWire <= srcToSel(w_grantIdx);
                        r_pcStall <= 1'b0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_selWire <= SEL_SEQ;
                        r_pcStall <= extStall;
                        r_busy    <= 1'b0;
                    end
                end
                REDIRECT: begin
                    // An external hold keeps the select on the branch unit
                    // so the redirect is taken once the hold clears.
                    if (extStall) begin
                        r_pcStall <= 1'b1;
                    end else begin
                        r_state    <= FLUSH;
                        r_selWire  <= SEL_SEQ;
                        r_pcStall  <= 1'b1;
                        r_flushCnt <= c_FLUSH_INIT;
                    end
                end
                FLUSH: begin
                    // Bubbles count down unconditionally; extStall only
                    // matters again once back in IDLE.
                    if (r_flushCnt == 4'd0) begin
                        r_state   <= IDLE;
                        r_pcStall <= extStall;
                        r_busy    <= 1'b0;
                    end else begin
                        r_flushCnt <= r_flushCnt - 4'd1;
                        r_pcStall  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_selWire <= SEL_SEQ;
                    r_pcStall <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign selWire     = r_selWire;
    assign pcStall     = r_pcStall;
    assign busy        = r_busy;
    assign jumpTarget1 = g_jumpTarget[0].r_jumpTarget;
    assign jumpTarget2 = g_jumpTarget[1].r_jumpTarget;
    assign jumpTarget3 = g_jumpTarget[2].r_jumpTarget;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_redirect_ctrl
// Description : Scoreboard bench for branch_redirect_ctrl. Three instances
//               with FLUSH_CYCLES = 2, 1 and 15 share clock, reset and
//               extStall; each has its own request sources. A cycle-level
//               reference model pushes expected outputs into a queue, and a
//               separate monitor pops and compares them mid low-phase.
//               Honours BRANCH_RR_ARB_EN when the RTL is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;
    import branchCtrlPkg::*;

    localparam int AW       = 20;
    localparam int NI       = 3;
    localparam int N_CYCLES = 3000;

    logic          clk = 1'b0;
    logic          rstN;
    logic          extStall;
    logic [2:0]    vValid [NI];
    logic [AW-1:0] vTgt   [NI][3];
    logic [2:0]    rdy    [NI];
    logic [1:0]    sel    [NI];
    logic [AW-1:0] jt     [NI][3];
    logic          pcS    [NI];
    logic          busyS  [NI];

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            branch_redirect_ctrl_if #(.ADDR_SIZE(AW)) rif ();

            assign rif.reqValid   = vValid[g];
            assign rif.reqTarget0 = vTgt[g][0];
            assign rif.reqTarget1 = vTgt[g][1];
            assign rif.reqTarget2 = vTgt[g][2];
            assign rdy[g]         = rif.reqReady;

            branch_redirect_ctrl #(
                .ADDR_SIZE    (AW),
                .FLUSH_CYCLES ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
            ) dut (
                .clk         (clk),
                .reset       (rstN),
                .req         (rif),
                .extStall    (extStall),
                .selWire     (sel[g]),
                .jumpTarget1 (jt[g][0]),
                .jumpTarget2 (jt[g][1]),
                .jumpTarget3 (jt[g][2]),
                .pcStall     (pcS[g]),
                .busy        (busyS[g])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    // Per instance: whether a redirect is being presented, how many bubble
    // cycles remain, what the branch unit currently sees, RR pointer.
    bit            mRedir [NI];
    int            mFlush [NI];
    int            mSel   [NI];
    logic [AW-1:0] mJt    [NI][3];
    bit            mPc    [NI];
    int            mPtr   [NI];
    bit            pend   [NI][3];

    typedef struct {
        int            inst;
        logic [2:0]    ready;
        logic [1:0]    sel;
        logic [AW-1:0] jt0, jt1, jt2;
        logic          pc;
        logic          busy;
    } exp_t;

    exp_t expQ[$];

    function automatic int flushLen(int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    endfunction

    function automatic bit isIdle(int g);
        return !mRedir[g] && (mFlush[g] == 0);
    endfunction

    function automatic void modelReset(int g);
        mRedir[g] = 0;
        mFlush[g] = 0;
        mSel[g]   = 0;
        mPc[g]    = 0;
        mPtr[g]   = 0;
        for (int i = 0; i < 3; i++) mJt[g][i] = '0;
    endfunction

    // Source granted this cycle, or -1.
    function automatic int modelGrant(int g);
        int start;
`ifdef BRANCH_RR_ARB_EN
        start = mPtr[g];
`else
        start = 0;
`endif
        if (!rstN || extStall || !isIdle(g)) return -1;
        for (int n = 0; n < 3; n++) begin
            if (vValid[g][(start + n) % 3]) return (start + n) % 3;
        end
        return -1;
    endfunction

    // What the next rising edge does to the observable outputs.
    function automatic void modelEdge(int g, int k);
        if (!rstN) return;
        if (mRedir[g]) begin
            if (extStall) begin
                mPc[g] = 1;
            end else begin
                mRedir[g] = 0;
                mSel[g]   = 0;
                mPc[g]    = 1;
                mFlush[g] = flushLen(g);
            end
        end else if (mFlush[g] > 0) begin
            mFlush[g] = mFlush[g] - 1;
            mPc[g]    = (mFlush[g] == 0) ? extStall : 1'b1;
        end else if (k >= 0) begin
            mJt[g][k]  = vTgt[g][k];
            mSel[g]    = k + 1;
            mPc[g]     = 0;
            mRedir[g]  = 1;
            mPtr[g]    = (k + 1) % 3;
            pend[g][k] = 0;
        end else begin
            mSel[g] = 0;
            mPc[g]  = extStall;
        end
    endfunction

    task automatic check(input string name, input int g, input logic [31:0] act,
                         input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    // ---------------- stimulus + model ----------------
    initial begin
        int   k;
        exp_t e;
        rstN     = 1'b0;
        extStall = 1'b0;
        for (int g = 0; g < NI; g++) begin
            modelReset(g);
            vValid[g] = 3'b000;
            for (int i = 0; i < 3; i++) begin
                pend[g][i] = 0;
                vTgt[g][i] = '0;
            end
        end

        for (int c = 0; c < N_CYCLES; c++) begin
            @(negedge clk);
            // Reset: held at start, then occasional random pulses.
            if (c < 3)                               rstN = 1'b0;
            else if (c >= 60 && $urandom_range(0, 40) == 0) rstN = 1'b0;
            else                                     rstN = 1'b1;

            if (c < 60) extStall = (c >= 31 && c < 34);
            else        extStall = ($urandom_range(0, 3) == 0);

            for (int g = 0; g < NI; g++) begin
                if (c == 3) begin
                    pend[g][1] = 1;
                    vTgt[g][1] = 20'h00ABC;
                end
                if (c == 20 || c == 45) begin
                    for (int i = 0; i < 3; i++) begin
                        if (!pend[g][i]) begin
                            pend[g][i] = 1;
                            vTgt[g][i] = AW'($urandom);
                        end
                    end
                end
                if (c >= 60) begin
                    for (int i = 0; i < 3; i++) begin
                        if (!pend[g][i] && $urandom_range(0, 2) == 0) begin
                            pend[g][i] = 1;
                            vTgt[g][i] = AW'($urandom);
                        end
                    end
                end
                for (int i = 0; i < 3; i++) vValid[g][i] = pend[g][i];
                if (!rstN) modelReset(g);
            end

            #1;
            for (int g = 0; g < NI; g++) begin
                k      = modelGrant(g);
                e.inst  = g;
                e.ready = (k >= 0) ? 3'(1 << k) : 3'b000;
                e.sel   = 2'(mSel[g]);
                e.jt0   = mJt[g][0];
                e.jt1   = mJt[g][1];
                e.jt2   = mJt[g][2];
                e.pc    = mPc[g];
                e.busy  = !isIdle(g);
                expQ.push_back(e);
                modelEdge(g, k);
            end
        end

        repeat (2) @(negedge clk);
        #3;
        if (expQ.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL scoreboard-drain: got %0d left expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        int   g;
        forever begin
            @(negedge clk);
            #2;
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                g = e.inst;
                check("reqReady",    g, 32'(rdy[g]),   32'(e.ready));
                check("selWire",     g, 32'(sel[g]),   32'(e.sel));
                check("jumpTarget1", g, 32'(jt[g][0]), 32'(e.jt0));
                check("jumpTarget2", g, 32'(jt[g][1]), 32'(e.jt1));
                check("jumpTarget3", g, 32'(jt[g][2]), 32'(e.jt2));
                check("pcStall",     g, 32'(pcS[g]),   32'(e.pc));
                check("busy",        g, 32'(busyS[g]), 32'(e.busy));
            end
        end
    end

endmodule
`default_nettype wire
